// File: rtl/alu_pkg.sv
// Shared ALU definitions: shift/rotate operation codes and default datapath widths.
package alu_pkg;

  // Default datapath width and matching shift-amount width (log2 of the width).
  localparam int DEFAULT_WIDTH    = 32;
  localparam int DEFAULT_SA_WIDTH = 5;

  // Shift/rotate operation select codes as they appear on the SRO bus.
  typedef enum logic [1:0] {
    SRO_SLL  = 2'b00,
    SRO_SRL  = 2'b01,
    SRO_SRA  = 2'b10,
    SRO_ROTR = 2'b11
  } sro_e;

endpackage

// File: rtl/shifter_stage.sv
// One level of the log shifter: conditionally shifts right by DIST, with the
// vacated top bits taken from the low bits of a separately supplied fill source.
module shifter_stage #(
  parameter int WIDTH = 32,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] din,
  input  logic [WIDTH-1:0] fill_src,
  input  logic             en,
  output logic [WIDTH-1:0] dout
);

  // Only the low DIST bits of the fill source ever enter the result; the rest
  // are deliberately ignored so every stage can share one full-width fill bus.
  logic w_unusedFill;
  assign w_unusedFill = ^fill_src[WIDTH-1:DIST];

  // Shift right by DIST when enabled, otherwise pass the data straight through.
  always_comb begin
    dout = din;
    if (en) begin
      dout = {fill_src[DIST-1:0], din[WIDTH-1:DIST]};
    end
  end

endmodule

// File: rtl/shifter.sv
// Registered 32-bit barrel shifter for the ALU: SLL, SRL, SRA and rotate-right.
// A single right-shifting log network is shared by all four operations; left
// shifts are done by bit-reversing the operand going in and the result coming out.
module shifter
  import alu_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int SA_WIDTH = DEFAULT_SA_WIDTH
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SA_WIDTH-1:0] SA,
  input  logic [1:0]          SRO,
  input  logic [WIDTH-1:0]    Data,
  output logic [WIDTH-1:0]    Result
);

  sro_e             w_op;
  logic             w_isLeft;
  logic             w_isRotate;
  logic             w_fillBit;
  logic [WIDTH-1:0] w_dataRev;
  logic [WIDTH-1:0] w_netRev;
  logic [WIDTH-1:0] w_shifted;
  logic [WIDTH-1:0] r_result;

  // w_stage[0] is the network input, w_stage[k+1] the output of stage k.
  logic [WIDTH-1:0] w_stage [SA_WIDTH+1];
  logic [WIDTH-1:0] w_fill  [SA_WIDTH];

  assign w_op = sro_e'(SRO);

  // Decode the operation into left/rotate flags and the single fill bit used by plain shifts.
  always_comb begin
    w_isLeft   = 1'b0;
    w_isRotate = 1'b0;
    w_fillBit  = 1'b0;
    case (w_op)
      SRO_SLL:  w_isLeft   = 1'b1;
      SRO_SRL:  w_fillBit  = 1'b0;
      SRO_SRA:  w_fillBit  = Data[WIDTH-1];
      SRO_ROTR: w_isRotate = 1'b1;
      default:  w_fillBit  = 1'b0;
    endcase
  end

  // Bit-reverse wiring for the operand and for the network output.
  for (genvar i = 0; i < WIDTH; i++) begin : g_reverse
    assign w_dataRev[i] = Data[WIDTH-1-i];
    assign w_netRev[i]  = w_stage[SA_WIDTH][WIDTH-1-i];
  end

  assign w_stage[0] = w_isLeft ? w_dataRev : Data;

  // Per-stage fill source: a rotate recycles the stage's own low bits, every other op shifts in the fill bit.
  always_comb begin
    for (int k = 0; k < SA_WIDTH; k++) begin
      w_fill[k] = {WIDTH{w_fillBit}};
      if (w_isRotate) begin
        w_fill[k] = w_stage[k];
      end
    end
  end

  // Stages run from the largest distance down to 1, each enabled by its own SA bit.
  for (genvar k = 0; k < SA_WIDTH; k++) begin : g_stage
    shifter_stage #(
      .WIDTH (WIDTH),
      .DIST  (1 << (SA_WIDTH-1-k))
    ) u_stage (
      .din      (w_stage[k]),
      .fill_src (w_fill[k]),
      .en       (SA[SA_WIDTH-1-k]),
      .dout     (w_stage[k+1])
    );
  end

  assign w_shifted = w_isLeft ? w_netRev : w_stage[SA_WIDTH];

  // Register the shifted value; a synchronous reset clears it and discards that cycle's operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_result <= '0;
    end else begin
      r_result <= w_shifted;
    end
  end

  assign Result = r_result;

endmodule

// File: tb/tb_shifter.sv
// Self-checking bench for the registered barrel shifter: directed vector table,
// hand-written reset sequences, and a random back-to-back sweep against a reference model.
module tb_shifter;

  logic        clk;
  logic        reset;
  logic [4:0]  SA;
  logic [1:0]  SRO;
  logic [31:0] Data;
  logic [31:0] Result;

  int checks;
  int failures;

  typedef struct {
    string       name;
    logic [1:0]  sro;
    logic [4:0]  sa;
    logic [31:0] data;
    logic [31:0] expected;
  } vector_t;

  vector_t vecs [19];

  shifter dut (
    .clk    (clk),
    .reset  (reset),
    .SA     (SA),
    .SRO    (SRO),
    .Data   (Data),
    .Result (Result)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Independent reference: straightforward operator-based shift/rotate.
  function automatic logic [31:0] refModel(input logic [1:0] op, input logic [4:0] amt,
                                           input logic [31:0] d);
    int n;
    n = int'(amt);
    case (op)
      2'b00:   return d << n;
      2'b01:   return d >> n;
      2'b10:   return 32'($signed(d) >>> n);
      default: return (n == 0) ? d : ((d >> n) | (d << (32 - n)));
    endcase
  endfunction

  // Drive one cycle's inputs on the falling edge, then wait for the capturing rising edge.
  task automatic applyStimulus(input logic rst, input logic [1:0] op, input logic [4:0] amt,
                               input logic [31:0] d);
    @(negedge clk);
    reset = rst;
    SRO   = op;
    SA    = amt;
    Data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] expected);
    checks++;
    if (Result !== expected) begin
      failures++;
      $display("[TB] FAIL %s: Result=%h expected=%h", name, Result, expected);
    end
  endtask

  initial begin
    logic [1:0]  rOp;
    logic [4:0]  rAmt;
    logic [31:0] rData;

    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    SRO      = 2'b00;
    SA       = 5'd0;
    Data     = 32'h0;

    vecs[0]  = '{"sll_sa31",     2'b00, 5'd31, 32'h0000_0001, 32'h8000_0000};
    vecs[1]  = '{"srl_sa31",     2'b01, 5'd31, 32'h8000_0000, 32'h0000_0001};
    vecs[2]  = '{"sra_sa31",     2'b10, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF};
    vecs[3]  = '{"sra_sa4",      2'b10, 5'd4,  32'h8000_0000, 32'hF800_0000};
    vecs[4]  = '{"rotr_sa4",     2'b11, 5'd4,  32'h0000_00F1, 32'h1000_000F};
    vecs[5]  = '{"sll_sa0",      2'b00, 5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[6]  = '{"srl_sa0",      2'b01, 5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[7]  = '{"sra_sa0",      2'b10, 5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[8]  = '{"rotr_sa0",     2'b11, 5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[9]  = '{"sll_sa4",      2'b00, 5'd4,  32'h1234_5678, 32'h2345_6780};
    vecs[10] = '{"srl_sa8",      2'b01, 5'd8,  32'h1234_5678, 32'h0012_3456};
    vecs[11] = '{"sra_pos_sa31", 2'b10, 5'd31, 32'h7FFF_FFFF, 32'h0000_0000};
    vecs[12] = '{"sra_pos_sa4",  2'b10, 5'd4,  32'h1234_5678, 32'h0123_4567};
    vecs[13] = '{"rotr_sa1",     2'b11, 5'd1,  32'h8000_0001, 32'hC000_0000};
    vecs[14] = '{"rotr_sa16",    2'b11, 5'd16, 32'h1234_5678, 32'h5678_1234};
    vecs[15] = '{"rotr_sa31",    2'b11, 5'd31, 32'h8000_0001, 32'h0000_0003};
    vecs[16] = '{"sll_sa31_b",   2'b00, 5'd31, 32'hA5A5_A5A4, 32'h0000_0000};
    vecs[17] = '{"sra_neg_sa8",  2'b10, 5'd8,  32'h8765_4321, 32'hFF87_6543};
    vecs[18] = '{"srl_neg_sa8",  2'b01, 5'd8,  32'h8765_4321, 32'h0087_6543};

    // Reset state after two cycles of reset.
    applyStimulus(1'b1, 2'b00, 5'd3, 32'h1234_5678);
    applyStimulus(1'b1, 2'b00, 5'd3, 32'h1234_5678);
    checkOutput("reset_state", 32'h0);

    // Directed vector table.
    foreach (vecs[i]) begin
      applyStimulus(1'b0, vecs[i].sro, vecs[i].sa, vecs[i].data);
      checkOutput(vecs[i].name, vecs[i].expected);
    end

    // Mid-stream reset beats a valid operation, which is then discarded.
    applyStimulus(1'b0, 2'b00, 5'd4, 32'h1234_5678);
    checkOutput("pre_reset_op", 32'h2345_6780);
    applyStimulus(1'b1, 2'b00, 5'd1, 32'hFFFF_FFFF);
    checkOutput("reset_wins", 32'h0);
    applyStimulus(1'b0, 2'b00, 5'd1, 32'hFFFF_FFFF);
    checkOutput("after_reset", 32'hFFFF_FFFE);

    // Full SRO x SA sweep with fresh random data each cycle, inputs changing every clock.
    for (int op = 0; op < 4; op++) begin
      for (int amt = 0; amt < 32; amt++) begin
        rOp   = 2'(op);
        rAmt  = 5'(amt);
        rData = $urandom;
        applyStimulus(1'b0, rOp, rAmt, rData);
        checkOutput("sweep", refModel(rOp, rAmt, rData));
      end
    end

    // Back-to-back toggling of SRO and SA every cycle.
    for (int n = 0; n < 64; n++) begin
      rOp   = 2'($urandom_range(0, 3));
      rAmt  = 5'($urandom_range(0, 31));
      rData = $urandom;
      applyStimulus(1'b0, rOp, rAmt, rData);
      checkOutput("b2b", refModel(rOp, rAmt, rData));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
